// File: rtl/fft_pkg.sv
// Shared definitions for the memory-based FFT datapath: default widths and
// the read-side tag that travels with each butterfly to its write-back.
package fft_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int NSTAGE  = 10;
    localparam int FIFO_AW = 3;

    typedef struct packed {
        logic              swap;
        logic [ADDR_W-1:0] addr_A;
        logic [ADDR_W-1:0] addr_B;
    } wr_tag_t;

    function automatic int tag_width(input int addr_w);
        return 1 + 2 * addr_w;
    endfunction

    function automatic int sidx_width(input int nstage);
        return (nstage > 1) ? $clog2(nstage) : 1;
    endfunction

endpackage

// File: rtl/fft_wr_bank_if.sv
// Tag capture, butterfly result and bank write-port bundle of the FFT
// write-back stage. The master drives tags and results; the slave is the stage.
interface fft_wr_bank_if
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int ADDR_W = fft_pkg::ADDR_W,
    parameter int NSTAGE = fft_pkg::NSTAGE
);
    localparam int SIDX_W = sidx_width(NSTAGE);

    logic              tag_push;
    logic              tag_swap;
    logic [ADDR_W-1:0] tag_addr_A;
    logic [ADDR_W-1:0] tag_addr_B;
    logic              tag_ready;

    logic              in_valid;
    logic [DATA_W-1:0] in_A;
    logic [DATA_W-1:0] in_B;

    logic              we_BANK0;
    logic [ADDR_W-1:0] addr_wr_BANK0;
    logic [DATA_W-1:0] data_wr_BANK0;
    logic              we_BANK1;
    logic [ADDR_W-1:0] addr_wr_BANK1;
    logic [DATA_W-1:0] data_wr_BANK1;

    logic [SIDX_W-1:0] stage_idx;
    logic              stage_done;
    logic              fft_done;
    logic [1:0]        err;

    modport master (
        output tag_push, tag_swap, tag_addr_A, tag_addr_B,
        output in_valid, in_A, in_B,
        input  tag_ready,
        input  we_BANK0, addr_wr_BANK0, data_wr_BANK0,
        input  we_BANK1, addr_wr_BANK1, data_wr_BANK1,
        input  stage_idx, stage_done, fft_done, err
    );

    modport slave (
        input  tag_push, tag_swap, tag_addr_A, tag_addr_B,
        input  in_valid, in_A, in_B,
        output tag_ready,
        output we_BANK0, addr_wr_BANK0, data_wr_BANK0,
        output we_BANK1, addr_wr_BANK1, data_wr_BANK1,
        output stage_idx, stage_done, fft_done, err
    );

endinterface

// File: rtl/fft_tag_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty and occupancy.
// Overflowing pushes and underflowing pops are ignored; no bypass paths.
module fft_tag_fifo #(
    parameter int W  = 19,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Full and empty are judged on the registered occupancy only, so a push
    // into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i  & ~empty_o;

    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fft_wr_bank.sv
// FFT write-back stage: queues read-side tags across the butterfly latency,
// steers results to the two bank write ports and tracks stage progress.
module fft_wr_bank
    import fft_pkg::*;
#(
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter int ADDR_W  = fft_pkg::ADDR_W,
    parameter int NSTAGE  = fft_pkg::NSTAGE,
    parameter int FIFO_AW = fft_pkg::FIFO_AW
) (
    input  logic          clk,
    input  logic          rstn,
    fft_wr_bank_if.slave  bus
);
    localparam int SIDX_W = sidx_width(NSTAGE);
    localparam int TAG_W  = tag_width(ADDR_W);
    localparam int DEPTH  = 1 << FIFO_AW;

    // Same layout as fft_pkg::wr_tag_t, sized by this instance's ADDR_W.
    typedef struct packed {
        logic              swap;
        logic [ADDR_W-1:0] addr_A;
        logic [ADDR_W-1:0] addr_B;
    } tag_t;

    tag_t             push_tag, head_tag;
    logic [TAG_W-1:0] head_bits;
    logic             fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             pop_ok, push_err, pop_err, last_bfly, last_stage;

    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr0_q,      addr0_d;
    logic [DATA_W-1:0] data0_q,      data0_d;
    logic [ADDR_W-1:0] addr1_q,      addr1_d;
    logic [DATA_W-1:0] data1_q,      data1_d;
    logic [ADDR_W-1:0] bfly_cnt_q,   bfly_cnt_d;
    logic [SIDX_W-1:0] stage_idx_q,  stage_idx_d;
    logic              stage_done_q, stage_done_d;
    logic              fft_done_q,   fft_done_d;
    logic [1:0]        err_q,        err_d;

    assign push_tag = '{swap: bus.tag_swap, addr_A: bus.tag_addr_A, addr_B: bus.tag_addr_B};
    assign head_tag = tag_t'(head_bits);

    fft_tag_fifo #(
        .W  (TAG_W),
        .AW (FIFO_AW)
    ) u_tag_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (bus.tag_push),
        .din_i   (push_tag),
        .pop_i   (bus.in_valid),
        .dout_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pop_ok     = bus.in_valid & ~fifo_empty;
    assign push_err   = bus.tag_push & fifo_full;
    assign pop_err    = bus.in_valid & fifo_empty;
    assign last_bfly  = (bfly_cnt_q == '1);
    assign last_stage = (stage_idx_q == SIDX_W'(NSTAGE - 1));

    always_comb begin
        we_d         = 1'b0;
        addr0_d      = addr0_q;
        data0_d      = data0_q;
        addr1_d      = addr1_q;
        data1_d      = data1_q;
        bfly_cnt_d   = bfly_cnt_q;
        stage_idx_d  = stage_idx_q;
        stage_done_d = 1'b0;
        fft_done_d   = 1'b0;
        err_d        = err_q | {pop_err, push_err};

        if (pop_ok) begin
            we_d = 1'b1;
            // swap=1 sends the upper operand to bank 0, otherwise to bank 1.
            if (head_tag.swap) begin
                addr0_d = head_tag.addr_A;  data0_d = bus.in_A;
                addr1_d = head_tag.addr_B;  data1_d = bus.in_B;
            end else begin
                addr1_d = head_tag.addr_A;  data1_d = bus.in_A;
                addr0_d = head_tag.addr_B;  data0_d = bus.in_B;
            end
            bfly_cnt_d = bfly_cnt_q + ADDR_W'(1);
            if (last_bfly) begin
                stage_done_d = 1'b1;
                if (last_stage) begin
                    stage_idx_d = '0;
                    fft_done_d  = 1'b1;
                end else begin
                    stage_idx_d = stage_idx_q + SIDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q         <= 1'b0;
            addr0_q      <= '0;
            data0_q      <= '0;
            addr1_q      <= '0;
            data1_q      <= '0;
            bfly_cnt_q   <= '0;
            stage_idx_q  <= '0;
            stage_done_q <= 1'b0;
            fft_done_q   <= 1'b0;
            err_q        <= '0;
        end else begin
            we_q         <= we_d;
            addr0_q      <= addr0_d;
            data0_q      <= data0_d;
            addr1_q      <= addr1_d;
            data1_q      <= data1_d;
            bfly_cnt_q   <= bfly_cnt_d;
            stage_idx_q  <= stage_idx_d;
            stage_done_q <= stage_done_d;
            fft_done_q   <= fft_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.tag_ready     = (fifo_count != (FIFO_AW+1)'(DEPTH));
    assign bus.we_BANK0      = we_q;
    assign bus.addr_wr_BANK0 = addr0_q;
    assign bus.data_wr_BANK0 = data0_q;
    assign bus.we_BANK1      = we_q;
    assign bus.addr_wr_BANK1 = addr1_q;
    assign bus.data_wr_BANK1 = data1_q;
    assign bus.stage_idx     = stage_idx_q;
    assign bus.stage_done    = stage_done_q;
    assign bus.fft_done      = fft_done_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_fft_wr_bank.sv
// Bench for fft_wr_bank at ADDR_W=3, NSTAGE=4, FIFO_AW=2: directed scenarios
// plus random traffic, every cycle compared against a queue-based model.
module tb_fft_wr_bank;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 3;
    localparam int NSTAGE  = 4;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int BFLY    = 1 << ADDR_W;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fft_wr_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSTAGE(NSTAGE)) bus ();

    fft_wr_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSTAGE(NSTAGE), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct { bit swap; int a; int b; } tag_m_t;

    tag_m_t      mq[$];
    int          m_writes;
    bit          m_we, m_sd, m_fd;
    int          m_a0, m_a1;
    logic [31:0] m_d0, m_d1;
    logic [1:0]  m_err;

    int n_assert = 0;
    int n_fail   = 0;
    int sd_seen  = 0;
    int fd_seen  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit push, input bit swap, input int a, input int b,
                         input bit valid, input logic [31:0] da, input logic [31:0] db);
        bus.tag_push   = push;
        bus.tag_swap   = swap;
        bus.tag_addr_A = ADDR_W'(a);
        bus.tag_addr_B = ADDR_W'(b);
        bus.in_valid   = valid;
        bus.in_A       = da;
        bus.in_B       = db;
    endtask

    // One clock: apply the reference rules to the inputs present at the edge,
    // then compare every output 1 time unit later.
    task automatic tick();
        bit          push  = bus.tag_push;
        bit          valid = bus.in_valid;
        bit          rst_n = rstn;
        tag_m_t      t_in  = '{swap: bus.tag_swap, a: int'(bus.tag_addr_A), b: int'(bus.tag_addr_B)};
        logic [31:0] da    = bus.in_A;
        logic [31:0] db    = bus.in_B;
        bit          full, empty;
        tag_m_t      t;

        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            m_writes = 0; m_we = 0; m_sd = 0; m_fd = 0;
            m_a0 = 0; m_a1 = 0; m_d0 = '0; m_d1 = '0; m_err = '0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            m_we = 0; m_sd = 0; m_fd = 0;
            if (valid && !empty) begin
                t = mq.pop_front();
                m_we = 1;
                if (t.swap) begin m_a0 = t.a; m_d0 = da; m_a1 = t.b; m_d1 = db; end
                else        begin m_a1 = t.a; m_d1 = da; m_a0 = t.b; m_d0 = db; end
                m_writes++;
                m_sd = (m_writes % BFLY == 0);
                m_fd = (m_writes % (BFLY * NSTAGE) == 0);
            end
            if (valid && empty) m_err[1] = 1'b1;
            if (push) begin
                if (full) m_err[0] = 1'b1;
                else      mq.push_back(t_in);
            end
        end

        check("tag_ready",  32'(bus.tag_ready),     32'(mq.size() < DEPTH));
        check("we_BANK0",   32'(bus.we_BANK0),      32'(m_we));
        check("we_BANK1",   32'(bus.we_BANK1),      32'(m_we));
        check("addr0",      32'(bus.addr_wr_BANK0), 32'(m_a0));
        check("data0",      bus.data_wr_BANK0,      m_d0);
        check("addr1",      32'(bus.addr_wr_BANK1), 32'(m_a1));
        check("data1",      bus.data_wr_BANK1,      m_d1);
        check("stage_idx",  32'(bus.stage_idx),     32'((m_writes / BFLY) % NSTAGE));
        check("stage_done", 32'(bus.stage_done),    32'(m_sd));
        check("fft_done",   32'(bus.fft_done),      32'(m_fd));
        check("err",        32'(bus.err),           32'(m_err));
        if (bus.stage_done === 1'b1) sd_seen++;
        if (bus.fft_done === 1'b1)   fd_seen++;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, '0, '0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    // n results back to back: one push ahead, then push+pop, then a final pop.
    task automatic run_pairs(input int n);
        for (int i = 0; i <= n; i++) begin
            drive(i < n, 1'($urandom_range(0, 1)), int'($urandom_range(0, BFLY - 1)),
                  int'($urandom_range(0, BFLY - 1)), i > 0, $urandom, $urandom);
            tick();
        end
        idle(1);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, '0, '0);
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        idle(1);

        // Single op, swap=0
        drive(1, 0, 3, 7, 0, '0, '0);           tick();
        idle(2);
        drive(0, 0, 0, 0, 1, 32'h0001_0002, 32'h0003_0004); tick();
        idle(1);

        // Swap op
        drive(1, 1, 2, 5, 0, '0, '0);           tick();
        idle(1);
        drive(0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h5555_FFFF); tick();
        idle(1);

        // Stage and FFT completion over 32 back-to-back butterflies
        do_reset();
        sd_seen = 0;
        fd_seen = 0;
        run_pairs(BFLY * NSTAGE);
        check("stage_done_count", 32'(sd_seen), 32'(NSTAGE));
        check("fft_done_count",   32'(fd_seen), 32'd1);

        // FIFO boundaries: fill, overflow, drain, underflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1'(i), i, 7 - i, 0, '0, '0);
            tick();
        end
        drive(1, 0, 6, 6, 0, '0, '0);           tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, $urandom, $urandom);
            tick();
        end
        drive(0, 0, 0, 0, 1, $urandom, $urandom); tick();
        idle(1);

        // Push into full FIFO while popping: still dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, i, i, 0, '0, '0);
            tick();
        end
        drive(1, 1, 5, 5, 1, $urandom, $urandom); tick();
        idle(1);

        // Reset mid-operation with tags pending at stage 2
        do_reset();
        run_pairs(2 * BFLY);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, i, i + 1, 0, '0, '0);
            tick();
        end
        drive(0, 0, 0, 0, 1, $urandom, $urandom);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        drive(0, 0, 0, 0, 1, $urandom, $urandom); tick();
        idle(1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, BFLY - 1)), int'($urandom_range(0, BFLY - 1)),
                  1'($urandom_range(0, 99) < 50), $urandom, $urandom);
            tick();
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_wr_bank.md
Name: fft_wr_bank

Overview:
- Write-back stage of the memory-based FFT; the write-side counterpart of the bank read register stage.
- Captures read-side tags {swap, upper address, lower address} when the read is issued. Holds them in a small tag FIFO across the variable butterfly latency.
- When butterfly results arrive, steers them to the BANK0/BANK1 write ports with registered outputs, for in-place update.
- Counts butterflies per stage; pulses stage_done and fft_done.

Parameters:
- DATA_W, 32, complex sample width ({re[15:0], im[15:0]}); pass-through only.
- ADDR_W, 9, per-bank address width. N = 2^(ADDR_W+1); butterflies per stage = 2^ADDR_W.
- NSTAGE, 10, number of radix-2 stages; must equal ADDR_W+1.
- FIFO_AW, 3, tag FIFO address width; depth = 2^FIFO_AW.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- tag_push  in  1  read issued this cycle (same cycle as en_REG_RD); push tag
- tag_swap  in  1  sel_rd_swap value used for this read
- tag_addr_A  in  ADDR_W  address of upper operand (sample A)
- tag_addr_B  in  ADDR_W  address of lower operand (sample B)
- tag_ready  out  1  tag FIFO not full
- in_valid  in  1  butterfly result pair valid; pops one tag
- in_A  in  DATA_W  butterfly upper output
- in_B  in  DATA_W  butterfly lower output
- we_BANK0  out  1  write enable, bank 0
- addr_wr_BANK0  out  ADDR_W  write address, bank 0
- data_wr_BANK0  out  DATA_W  write data, bank 0
- we_BANK1  out  1  write enable, bank 1
- addr_wr_BANK1  out  ADDR_W  write address, bank 1
- data_wr_BANK1  out  DATA_W  write data, bank 1
- stage_idx  out  clog2(NSTAGE)  current stage
- stage_done  out  1  one-cycle pulse with the last write of a stage
- fft_done  out  1  one-cycle pulse with the last write of stage NSTAGE-1
- err  out  2  sticky: [0] push while full, [1] pop while empty

Behaviour:
- Reset values (synchronous, rstn=0 at posedge):
  - FIFO emptied; tag_ready=1.
  - All we_*=0; addr_wr_*=0; data_wr_*=0.
  - stage_idx=0; butterfly counter=0; stage_done=0; fft_done=0; err=0.
- Reset mid-operation: pending tags are discarded, and no write issues in the cycle after the reset edge.
- Tag FIFO:
  - Synchronous FIFO, 1+2*ADDR_W bits wide, first-word-fall-through on the read side.
  - Push accepted when tag_push=1 and not full.
  - Push while full: tag dropped, err[0] set. This holds even if in_valid pops in the same cycle; there is no full-bypass.
  - Pop when in_valid=1 and not empty.
  - Pop while empty: no write, counter unchanged, err[1] set. This holds even with a simultaneous push; there is no empty-bypass.
  - Simultaneous push+pop when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo depth; occupancy counter is FIFO_AW+1 bits.
- Write steering, registered (in_valid at edge t gives we at t+1):
  - swap=0: BANK1 <= (tag_addr_A, in_A); BANK0 <= (tag_addr_B, in_B).
  - swap=1: BANK0 <= (tag_addr_A, in_A); BANK1 <= (tag_addr_B, in_B).
  - Both we asserted together for exactly one cycle per accepted pop.
  - addr/data hold their last value when we=0.
- Stage counting:
  - ADDR_W-bit butterfly counter increments per accepted pop.
  - When the counter is at 2^ADDR_W-1 and a pop occurs:
    - counter wraps to 0;
    - stage_done pulses in the same cycle as that write's we;
    - stage_idx increments, or wraps to 0 from NSTAGE-1, in which case fft_done also pulses.
  - stage_idx changes on the same edge that raises stage_done.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
- Shared package fft_pkg:
  - DATA_W, ADDR_W, NSTAGE constants;
  - typedef wr_tag_t {swap, addr_A, addr_B}, also used by the address generator and the read stage.
- One sub-module: fft_tag_fifo (parameterised sync FWFT FIFO with full/empty and occupancy).
- Steering and counters stay in the top.

Test Plan (ADDR_W=3, NSTAGE=4, FIFO_AW=2):
- Single op: push {swap=0, A=3, B=7}; 3 cycles later in_valid, in_A=0x00010002, in_B=0x00030004. Next cycle: we_BANK1=1 addr 3 data 0x00010002; we_BANK0=1 addr 7 data 0x00030004; stage_idx=0.
- Swap: push {swap=1, A=2, B=5}, then valid with in_A=0xAAAA0000, in_B=0x5555FFFF. BANK0 gets addr 2/0xAAAA0000; BANK1 gets addr 5/0x5555FFFF.
- Stage/fft completion: 32 back-to-back push/pop pairs.
  - stage_done on the writes numbered 8, 16, 24, 32; stage_idx sequence 0→1→2→3→0.
  - fft_done only with write 32.
- FIFO boundaries:
  - 4 pushes without pops: tag_ready=0.
  - 5th push: dropped, err=2'b01.
  - 4 pops drain in order; a 5th in_valid: no we, err=2'b11.
- Reset mid-operation: 3 tags pending and stage_idx=2, pulse rstn=0 for 1 cycle.
  - Next cycle: we=0, tag_ready=1, stage_idx=0, err=0.
  - A following in_valid sets err[1].
